// File: rtl/fp_addsub_pipe.sv
// Five-stage pipelined floating-point adder/subtractor with valid/ready
// handshake, round-to-nearest-even, flush-to-zero and per-result flags.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic [TAG_W-1:0]         tag_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     c,
  output logic [TAG_W-1:0]         tag_out,
  output logic [2:0]               flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 4;
  localparam int LZW = $clog2(M + 1);
  localparam int EW  = EXP_W + 2;

  localparam logic [EXP_W-1:0] EMAX    = '1;
  localparam logic [EXP_W-1:0] SAT     = EXP_W'(M);
  localparam logic [M-1:0]     ONES    = '1;
  localparam logic [W-2:0]     INF_MAG = {EMAX, {MAN_W{1'b0}}};
  localparam logic [W-1:0]     QNAN    =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             spec;
    logic [W-1:0]     sval;
    logic             inv;
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
  } hdr_t;

  typedef struct packed {
    hdr_t             h;
    logic [EXP_W-1:0] diff;
    logic [MAN_W:0]   mbig;
    logic [MAN_W:0]   msml;
  } s1_t;

  typedef struct packed {
    hdr_t         h;
    logic [M-1:0] big;
    logic [M-1:0] sml;
  } s2_t;

  typedef struct packed {
    hdr_t       h;
    logic [M:0] sum;
  } s3_t;

  typedef struct packed {
    hdr_t           h;
    logic [M:0]     sum;
    logic [LZW-1:0] lz;
    logic           zero;
  } s4_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     c;
    logic [2:0]       flags;
  } s5_t;

  s1_t r1, n1;
  s2_t r2, n2;
  s3_t r3, n3;
  s4_t r4, n4;
  s5_t r5, n5;

  logic adv;
  assign adv      = !r5.vld || out_ready;
  assign in_ready = adv;

  function automatic logic [LZW-1:0] lzc(input logic [M-1:0] v);
    lzc = LZW'(M);
    for (int i = 0; i < M; i++)
      if (v[i]) lzc = LZW'(M - 1 - i);
  endfunction

  // S1: unpack, classify, magnitude compare
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [W-2:0]     mag_a, mag_b;
  logic [MAN_W:0]   ma, mb;

  assign sa     = a[W-1];
  assign sb     = b[W-1] ^ op;
  assign ea     = a[W-2:MAN_W];
  assign eb     = b[W-2:MAN_W];
  assign fa     = a[MAN_W-1:0];
  assign fb     = b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_nan  = (ea == EMAX) && (|fa);
  assign b_nan  = (eb == EMAX) && (|fb);
  assign a_inf  = (ea == EMAX) && !(|fa);
  assign b_inf  = (eb == EMAX) && !(|fb);
  assign mag_a  = a_zero ? '0 : a[W-2:0];
  assign mag_b  = b_zero ? '0 : b[W-2:0];
  assign ma     = a_zero ? '0 : {1'b1, fa};
  assign mb     = b_zero ? '0 : {1'b1, fb};
  assign a_big  = (mag_a >= mag_b);

  always_comb begin
    n1       = '0;
    n1.h.vld = in_valid;
    n1.h.tag = tag_in;
    n1.h.sub = sa ^ sb;
    if (a_nan || b_nan) begin
      n1.h.spec = 1'b1;
      n1.h.sval = QNAN;
      n1.h.inv  = 1'b1;
    end else if (a_inf && b_inf) begin
      n1.h.spec = 1'b1;
      n1.h.sval = n1.h.sub ? QNAN : {sa, INF_MAG};
      n1.h.inv  = n1.h.sub;
    end else if (a_inf) begin
      n1.h.spec = 1'b1;
      n1.h.sval = {sa, INF_MAG};
    end else if (b_inf) begin
      n1.h.spec = 1'b1;
      n1.h.sval = {sb, INF_MAG};
    end
    if (a_big) begin
      n1.h.sign = sa;
      n1.h.exp  = ea;
      n1.diff   = ea - eb;
      n1.mbig   = ma;
      n1.msml   = mb;
    end else begin
      n1.h.sign = sb;
      n1.h.exp  = eb;
      n1.diff   = eb - ea;
      n1.mbig   = mb;
      n1.msml   = ma;
    end
  end

  // S2: align the smaller mantissa, collapsing lost bits into sticky
  logic [M-1:0] sh_ext, sh_out;
  logic         stk;

  always_comb begin
    n2     = '0;
    sh_ext = {r1.msml, 3'b000};
    if (r1.diff >= SAT) begin
      sh_out = '0;
      stk    = |r1.msml;
    end else begin
      sh_out = sh_ext >> r1.diff;
      stk    = |(sh_ext & ~(ONES << r1.diff));
    end
    n2.h   = r1.h;
    n2.big = {r1.mbig, 3'b000};
    n2.sml = sh_out | {{(M-1){1'b0}}, stk};
  end

  // S3: effective add or subtract
  always_comb begin
    n3     = '0;
    n3.h   = r2.h;
    n3.sum = r2.h.sub ? ({1'b0, r2.big} - {1'b0, r2.sml})
                      : ({1'b0, r2.big} + {1'b0, r2.sml});
  end

  // S4: leading-zero count and cancellation detect
  always_comb begin
    n4      = '0;
    n4.h    = r3.h;
    n4.sum  = r3.sum;
    n4.lz   = lzc(r3.sum[M-1:0]);
    n4.zero = ~|r3.sum;
  end

  // S5: normalise, round, pack
  logic [M-1:0]          norm;
  logic signed [EW-1:0]  e, er;
  logic [MAN_W+1:0]      mr;
  logic [MAN_W-1:0]      man;
  logic                  inc;

  always_comb begin
    n5     = '0;
    n5.vld = r4.h.vld;
    n5.tag = r4.h.tag;
    if (r4.sum[M]) begin
      norm = {r4.sum[M:2], r4.sum[1] | r4.sum[0]};
      e    = $signed({2'b00, r4.h.exp}) + $signed(EW'(1));
    end else begin
      norm = r4.sum[M-1:0] << r4.lz;
      e    = $signed({2'b00, r4.h.exp})
           - $signed({{(EW-LZW){1'b0}}, r4.lz});
    end
    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    mr  = {1'b0, norm[M-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    er  = mr[MAN_W+1] ? e + $signed(EW'(1)) : e;
    man = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    if (r4.h.spec) begin
      n5.c     = r4.h.sval;
      n5.flags = {r4.h.inv, 2'b00};
    end else if (r4.zero) begin
      n5.c = {r4.h.sign & ~r4.h.sub, {(W-1){1'b0}}};
    end else if (e <= $signed(EW'(0))) begin
      n5.c     = {r4.h.sign, {(W-1){1'b0}}};
      n5.flags = 3'b001;
    end else if (er >= $signed({2'b00, EMAX})) begin
      n5.c     = {r4.h.sign, INF_MAG};
      n5.flags = 3'b010;
    end else begin
      n5.c = {r4.h.sign, er[EXP_W-1:0], man};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      r4 <= '0;
      r5 <= '0;
    end else if (adv) begin
      r1 <= n1;
      r2 <= n2;
      r3 <= n3;
      r4 <= n4;
      r5 <= n5;
    end
  end

  assign out_valid = r5.vld;
  assign c         = r5.c;
  assign tag_out   = r5.tag;
  assign flags     = r5.flags;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: single-precision and half-precision
// instances, specials, rounding, backpressure and mid-stream reset.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, c;
  logic [3:0]  tag_in, tag_out;
  logic [2:0]  flags;

  logic        in_valid_h, in_ready_h, op_h, out_valid_h, out_ready_h;
  logic [15:0] a_h, b_h, c_h;
  logic [3:0]  tag_in_h, tag_out_h;
  logic [2:0]  flags_h;

  int ncmp = 0;
  int nfail = 0;
  logic [3:0] tg = 4'd0;

  always #5 clk = ~clk;

  fp_addsub_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .tag_out(tag_out), .flags(flags)
  );

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_h), .in_ready(in_ready_h),
    .op(op_h), .a(a_h), .b(b_h), .tag_in(tag_in_h),
    .out_valid(out_valid_h), .out_ready(out_ready_h),
    .c(c_h), .tag_out(tag_out_h), .flags(flags_h)
  );

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, expv);
    end
  endtask

  task automatic run1(input string nm, input logic [31:0] va,
                      input logic [31:0] vb, input logic vop,
                      input logic [31:0] ec, input logic [2:0] ef);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    op        = vop;
    tag_in    = tg;
    out_ready = 1'b1;
    #1 chk({nm, "/rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "/lat"}, n, 32'd5);
    chk({nm, "/c"}, c, ec);
    chk({nm, "/flags"}, {29'd0, flags}, {29'd0, ef});
    chk({nm, "/tag"}, {28'd0, tag_out}, {28'd0, tg});
    tg = tg + 4'd1;
  endtask

  logic [31:0] sa_v [8];
  logic [31:0] sb_v [8];
  logic [31:0] sc_v [8];
  logic        so_v [8];

  initial begin
    int sent, got, nv;
    logic stall_prev;
    logic [31:0] c_prev;
    logic [3:0]  t_prev;

    rst_n = 1'b0;
    in_valid = 1'b0; op = 1'b0; a = '0; b = '0; tag_in = '0;
    out_ready = 1'b1;
    in_valid_h = 1'b0; op_h = 1'b0; a_h = '0; b_h = '0; tag_in_h = '0;
    out_ready_h = 1'b1;

    sa_v[0] = 32'h3F800000; sb_v[0] = 32'h3F800000; so_v[0] = 0; sc_v[0] = 32'h40000000;
    sa_v[1] = 32'h40000000; sb_v[1] = 32'h3F800000; so_v[1] = 0; sc_v[1] = 32'h40400000;
    sa_v[2] = 32'h40400000; sb_v[2] = 32'h3F800000; so_v[2] = 0; sc_v[2] = 32'h40800000;
    sa_v[3] = 32'h3F800000; sb_v[3] = 32'h40000000; so_v[3] = 0; sc_v[3] = 32'h40400000;
    sa_v[4] = 32'h40800000; sb_v[4] = 32'h3F800000; so_v[4] = 0; sc_v[4] = 32'h40A00000;
    sa_v[5] = 32'h40400000; sb_v[5] = 32'h3F800000; so_v[5] = 1; sc_v[5] = 32'h40000000;
    sa_v[6] = 32'h40800000; sb_v[6] = 32'h3F800000; so_v[6] = 1; sc_v[6] = 32'h40400000;
    sa_v[7] = 32'h40000000; sb_v[7] = 32'h40000000; so_v[7] = 0; sc_v[7] = 32'h40800000;

    #12;
    chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst/c", c, 32'd0);
    chk("rst/tag", {28'd0, tag_out}, 32'd0);
    chk("rst/flags", {29'd0, flags}, 32'd0);
    chk("rst/in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run1("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000);
    run1("cancel",       32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 3'b000);
    run1("three_m_one",  32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 3'b000);
    run1("rne_tie",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    run1("rne_up",       32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b000);
    run1("rne_odd",      32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
    run1("inf_m_inf",    32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100);
    run1("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010);
    run1("underflow",    32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001);
    run1("nan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
    run1("x_plus_nz",    32'h40400000, 32'h80000000, 1'b0, 32'h40400000, 3'b000);
    run1("nz_plus_nz",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000);
    run1("pz_plus_nz",   32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000);
    run1("one_m_inf",    32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 3'b000);
    run1("denorm_ftz",   32'h3F800000, 32'h00400000, 1'b0, 32'h3F800000, 3'b000);

    // backpressure stream
    sent = 0;
    got = 0;
    stall_prev = 1'b0;
    c_prev = '0;
    t_prev = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc <= 8);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a      = sa_v[sent];
        b      = sb_v[sent];
        op     = so_v[sent];
        tag_in = 4'(sent);
      end
      #1;
      if (stall_prev) begin
        chk("bp/hold_c", c, c_prev);
        chk("bp/hold_tag", {28'd0, tag_out}, {28'd0, t_prev});
      end
      if (!out_ready)
        chk("bp/in_ready", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (got < 8) begin
          chk("bp/c", c, sc_v[got]);
          chk("bp/tag", {28'd0, tag_out}, 32'(got));
        end
        got++;
      end
      stall_prev = out_valid && !out_ready;
      c_prev = c;
      t_prev = tag_out;
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    chk("bp/count", got, 32'd8);

    // reset with operations in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h3F800000;
      b = 32'h3F800000;
      op = 1'b0;
      tag_in = 4'(i + 9);
    end
    @(negedge clk);
    in_valid = 1'b0;
    nv = 0;
    while (!out_valid && nv < 20) begin
      @(negedge clk);
      nv++;
    end
    chk("mrst/reached_out", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst/out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst/c", c, 32'd0);
    chk("mrst/tag", {28'd0, tag_out}, 32'd0);
    chk("mrst/flags", {29'd0, flags}, 32'd0);
    chk("mrst/in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("mrst/no_stale", nv, 32'd0);
    run1("post_rst", 32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000);

    // half-precision instance
    @(negedge clk);
    in_valid_h = 1'b1;
    a_h = 16'h3C00;
    b_h = 16'h3C00;
    op_h = 1'b0;
    tag_in_h = 4'd5;
    @(posedge clk);
    @(negedge clk);
    in_valid_h = 1'b0;
    nv = 1;
    while (!out_valid_h && nv < 20) begin
      @(negedge clk);
      nv++;
    end
    chk("half/lat", nv, 32'd5);
    chk("half/c", {16'd0, c_h}, 32'h00004000);
    chk("half/flags", {29'd0, flags_h}, 32'd0);
    chk("half/tag", {28'd0, tag_out_h}, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; successor to the fixed 32-bit FPU add/sub unit. Adds a valid/ready handshake with backpressure, round-to-nearest-even, special-value handling, status flags and a tag passthrough. Sits in the FPU datapath between the issue stage and writeback.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa width (hidden bit excluded)
TAG_W, 4, opaque tag carried alongside each operation
Derived: W = 1+EXP_W+MAN_W; guard/round/sticky bits are internal, 3 extra LSBs.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands present
in_ready  out  1  pipe accepts operands this cycle
op  in  1  0 = A+B, 1 = A-B
a  in  W  operand A {sign, exp, man}
b  in  W  operand B
tag_in  in  TAG_W  tag
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
c  out  W  result
tag_out  out  TAG_W  tag of result
flags  out  3  {invalid, overflow, underflow}, valid with c

Behaviour:
- Reset (rst_n low, async): all stage valid bits 0; out_valid=0, c=0, tag_out=0, flags=0. in_ready is 1 after reset. Operations in flight are discarded; none emerge after reset release.
- Five stages, latency 5 cycles from accepted input to out_valid with no stall: S1 unpack/classify/exp compare; S2 align (right shift smaller mantissa, shift >= MAN_W+4 saturates, shifted-out bits OR into sticky); S3 effective add/sub of MAN_W+4-bit mantissas, sign select; S4 leading-zero count / carry detect; S5 normalise, RNE round, re-normalise on round carry, exponent adjust, pack.
- Handshake: advance = !out_valid || out_ready. All stages shift only when advance=1; in_ready = advance. Input accepted when in_valid && in_ready. Output consumed when out_valid && out_ready. Bubbles are carried (stage valid=0) and do not squeeze when stalled; throughput 1 op/cycle when out_ready held high.
- While out_valid && !out_ready: c, tag_out, flags held stable.
- Effective op: subtract when (sa ^ sb ^ op)=1. B's sign is inverted when op=1.
- Larger-magnitude operand (exp, then mantissa on tie) supplies result sign; exact cancellation yields +0 (sign 0).
- Rounding: round-to-nearest, ties-to-even using guard/round/sticky.
- Special values (decided in S1, bypass arithmetic, same latency):
  - exp=0 inputs (zero or denormal) treated as signed zero (flush-to-zero).
  - either NaN -> canonical quiet NaN {0, all-ones exp, 1 in MSB of man, rest 0}, invalid=1.
  - +inf + -inf (effective subtract of infs) -> canonical NaN, invalid=1.
  - inf with finite -> that inf (sign after op applied).
  - x + 0 -> x; (+0)+(-0) -> +0; (-0)+(-0) -> -0.
- Overflow: biased result exp >= all-ones after rounding -> ±inf, overflow=1.
- Underflow: normalised biased exp <= 0 -> ±0 (flush), underflow=1.
- Flags are per-result, not sticky.

Test Plan:
- 32-bit defaults, out_ready=1: a=0x3F800000, b=0x3F800000, op=0 -> c=0x40000000 exactly 5 cycles after accept, flags=000.
- a=0x3FC00000, b=0x3FC00000, op=1 -> c=0x00000000 (+0); a=0x40400000 (3.0), b=0xBF800000 (-1.0), op=0 -> c=0x40000000.
- Rounding: a=0x3F800000 + b=0x33800000 (tie) -> 0x3F800000; b=0x33800001 -> 0x3F800001; a=0x3F800001 + b=0x33800000 -> 0x3F800002.
- Specials: 0x7F800000 + 0xFF800000 -> 0x7FC00000, flags=100; 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags=010; 0x00800000 - 0x00800001 -> 0x80000000, flags=001; 0x7FC00001 + 1.0 -> 0x7FC00000, flags=100.
- Backpressure: stream 8 back-to-back ops, drop out_ready for 3 cycles mid-stream -> in_ready low those cycles, c/tag_out stable, all 8 results appear in order with matching tags, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> out_valid=0 immediately; after release no stale results; EXP_W=5, MAN_W=10 instance: 0x3C00+0x3C00 -> 0x4000.
